grid_lcd_writer: RTL and testbench

- Reads the 16-bit dino grid produced by the movement block and draws it on an HD44780-style 2-line character LCD over an 8-bit parallel bus.
- grid[15:8] is drawn on LCD line 1 (up row) and grid[7:0] on line 2 (down row), 8 columns each.
- Runs the LCD init sequence after reset, then redraws the full frame whenever the grid changes.

---
 rtl/dino_lcd_pkg.sv | 35 +++
 rtl/grid_lcd_writer_if.sv | 10 +
 rtl/lcd_byte_tx.sv | 110 +++++++++++
 rtl/grid_lcd_writer.sv | 119 +++++++++++
 tb/tb_grid_lcd_writer.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dino_lcd_pkg.sv
// rtl/dino_lcd_pkg.sv - LCD command codes, FSM state types and sequence helpers
package dino_lcd_pkg;

  localparam logic [7:0] LCD_FUNC_SET = 8'h38;
  localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
  localparam logic [7:0] LCD_ENTRY    = 8'h06;
  localparam logic [7:0] LCD_CLEAR    = 8'h01;
  localparam logic [7:0] LCD_LINE1    = 8'h80;
  localparam logic [7:0] LCD_LINE2    = 8'hC0;

  // number of bytes in each sequence; the index counts bytes already launched
  localparam logic [4:0] INIT_LEN  = 5'd4;
  localparam logic [4:0] FRAME_LEN = 5'd18;

  typedef enum logic [1:0] {INIT, IDLE, FRAME} top_state_t;
  typedef enum logic [1:0] {SETUP, PULSE, HOLD} tx_state_t;

  // init command for a given position in the init sequence
  function automatic logic [7:0] init_cmd(input logic [4:0] idx);
    case (idx)
      5'd0:    return LCD_FUNC_SET;
      5'd1:    return LCD_DISP_ON;
      5'd2:    return LCD_ENTRY;
      default: return LCD_CLEAR;
    endcase
  endfunction

  // grid bit drawn by a frame data byte: positions 1..8 walk bit 15..8,
  // positions 10..17 walk bit 7..0 (positions 0 and 9 are line addresses)
  function automatic logic [3:0] frame_bit(input logic [4:0] idx);
    if (idx <= 5'd8) return 4'(5'd16 - idx);
    else             return 4'(5'd17 - idx);
  endfunction

endpackage

// File: rtl/grid_lcd_writer_if.sv
// rtl/grid_lcd_writer_if.sv - 8-bit parallel HD44780 write bus
interface grid_lcd_writer_if;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_e;
  logic [7:0] lcd_data;

  modport master (output lcd_rs, output lcd_rw, output lcd_e, output lcd_data);
  modport slave  (input  lcd_rs, input  lcd_rw, input  lcd_e, input  lcd_data);
endinterface

// File: rtl/lcd_byte_tx.sv
// rtl/lcd_byte_tx.sv - one LCD byte write: setup, enable pulse, hold
module lcd_byte_tx
  import dino_lcd_pkg::*;
#(
  parameter int E_PULSE  = 2,
  parameter int CMD_WAIT = 4,
  parameter int CLR_WAIT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       rs_in,
  input  logic [7:0] byte_in,
  input  logic       long_wait,
  output logic       lcd_rs,
  output logic       lcd_e,
  output logic [7:0] lcd_data,
  output logic       done
);

  localparam int LONG_WAIT = CMD_WAIT + CLR_WAIT;
  localparam int MAX_CNT   = (LONG_WAIT > E_PULSE) ? LONG_WAIT : E_PULSE;
  localparam int CW        = $clog2(MAX_CNT + 1);

  localparam logic [CW-1:0] ONE        = CW'(1);
  localparam logic [CW-1:0] E_LAST     = CW'(E_PULSE - 1);
  localparam logic [CW-1:0] SHORT_LAST = CW'(CMD_WAIT - 1);
  localparam logic [CW-1:0] LONG_LAST  = CW'(LONG_WAIT - 1);

  logic          active, active_n;
  tx_state_t     st, st_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          rs_q, long_q;
  logic [7:0]    data_q;
  logic [CW-1:0] hold_last;
  logic          done_i;
  logic          accept;

  assign hold_last = long_q ? LONG_LAST : SHORT_LAST;
  assign done_i    = active && (st == HOLD) && (cnt == hold_last);
  // a new byte may start while idle or on the last hold cycle, so bytes chain with no gap
  assign accept    = start && (!active || done_i);

  // state register: reset abandons any byte in flight
  always_ff @(posedge clk) begin
    if (!reset) begin
      active <= 1'b0;
      st     <= SETUP;
      cnt    <= '0;
    end else begin
      active <= active_n;
      st     <= st_n;
      cnt    <= cnt_n;
    end
  end

  // next-state: walk SETUP -> PULSE -> HOLD with a per-phase cycle counter
  always_comb begin
    active_n = active;
    st_n     = st;
    cnt_n    = cnt;
    if (accept) begin
      active_n = 1'b1;
      st_n     = SETUP;
      cnt_n    = '0;
    end else if (active) begin
      case (st)
        SETUP: begin
          st_n  = PULSE;
          cnt_n = '0;
        end
        PULSE: begin
          if (cnt == E_LAST) begin
            st_n  = HOLD;
            cnt_n = '0;
          end else begin
            cnt_n = cnt + ONE;
          end
        end
        HOLD: begin
          if (cnt == hold_last) active_n = 1'b0;
          else                  cnt_n    = cnt + ONE;
        end
        default: active_n = 1'b0;
      endcase
    end
  end

  // latch rs/data/wait length at start so they stay stable for the whole byte
  always_ff @(posedge clk) begin
    if (!reset) begin
      rs_q   <= 1'b0;
      data_q <= 8'h00;
      long_q <= 1'b0;
    end else if (accept) begin
      rs_q   <= rs_in;
      data_q <= byte_in;
      long_q <= long_wait;
    end
  end

  // outputs: enable high only during PULSE
  always_comb begin
    lcd_e    = active && (st == PULSE);
    lcd_rs   = rs_q;
    lcd_data = data_q;
    done     = done_i;
  end

endmodule

// File: rtl/grid_lcd_writer.sv
// rtl/grid_lcd_writer.sv - draws the 2x8 dino grid on a character LCD
module grid_lcd_writer
  import dino_lcd_pkg::*;
#(
  parameter int         E_PULSE    = 2,
  parameter int         CMD_WAIT   = 4,
  parameter int         CLR_WAIT   = 8,
  parameter logic [7:0] DINO_CHAR  = 8'h2A,
  parameter logic [7:0] EMPTY_CHAR = 8'h20
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [15:0]               grid,
  grid_lcd_writer_if.master         lcd,
  output logic                      busy,
  output logic                      frame_done
);

  top_state_t  state, state_n;
  logic [4:0]  idx;
  logic        kick;
  logic        dirty;
  logic [15:0] snap, shadow;
  logic        busy_q;

  logic        tx_start, tx_rs, tx_long, tx_done;
  logic [7:0]  tx_byte;
  logic        bus_rs, bus_e;
  logic [7:0]  bus_data;
  logic [4:0]  seq_len;

  lcd_byte_tx #(
    .E_PULSE  (E_PULSE),
    .CMD_WAIT (CMD_WAIT),
    .CLR_WAIT (CLR_WAIT)
  ) u_tx (
    .clk       (clk),
    .reset     (reset),
    .start     (tx_start),
    .rs_in     (tx_rs),
    .byte_in   (tx_byte),
    .long_wait (tx_long),
    .lcd_rs    (bus_rs),
    .lcd_e     (bus_e),
    .lcd_data  (bus_data),
    .done      (tx_done)
  );

  assign lcd.lcd_rs   = bus_rs;
  assign lcd.lcd_rw   = 1'b0;
  assign lcd.lcd_e    = bus_e;
  assign lcd.lcd_data = bus_data;
  assign busy         = busy_q;

  assign seq_len  = (state == INIT) ? INIT_LEN : FRAME_LEN;
  // first byte of a sequence is kicked off explicitly; the rest chain off done
  assign tx_start = (state != IDLE) && (kick || (tx_done && (idx != seq_len)));

  // state register
  always_ff @(posedge clk) begin
    if (!reset) state <= INIT;
    else        state <= state_n;
  end

  // next-state: leave a sequence when its last byte completes; redraw on change
  always_comb begin
    state_n = state;
    case (state)
      INIT:    if (tx_done && (idx == INIT_LEN)) state_n = IDLE;
      IDLE:    if (dirty || (grid != shadow))    state_n = FRAME;
      FRAME:   if (tx_done && (idx == FRAME_LEN)) state_n = IDLE;
      default: state_n = INIT;
    endcase
  end

  // outputs: byte selection for the current sequence position and frame strobe
  always_comb begin
    tx_rs      = 1'b0;
    tx_byte    = 8'h00;
    frame_done = (state == FRAME) && tx_done && (idx == FRAME_LEN);
    if (state == INIT) begin
      tx_byte = init_cmd(idx);
    end else if (state == FRAME) begin
      if (idx == 5'd0) begin
        tx_byte = LCD_LINE1;
      end else if (idx == 5'd9) begin
        tx_byte = LCD_LINE2;
      end else begin
        tx_rs   = 1'b1;
        tx_byte = snap[frame_bit(idx)] ? DINO_CHAR : EMPTY_CHAR;
      end
    end
    tx_long = !tx_rs && (tx_byte == LCD_CLEAR);
  end

  // sequencer bookkeeping: byte index, kick, frame snapshot and change tracking
  always_ff @(posedge clk) begin
    if (!reset) begin
      idx    <= 5'd0;
      kick   <= 1'b1;
      dirty  <= 1'b1;
      snap   <= 16'h0000;
      shadow <= 16'h0000;
      busy_q <= 1'b0;
    end else begin
      busy_q <= (state_n != IDLE);
      if (state_n != state) idx <= 5'd0;
      else if (tx_start)    idx <= idx + 5'd1;
      if (tx_start) kick <= 1'b0;
      if ((state == IDLE) && (state_n == FRAME)) begin
        kick   <= 1'b1;
        snap   <= grid;
        shadow <= grid;
        dirty  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_grid_lcd_writer.sv
// tb/tb_grid_lcd_writer.sv - directed self-checking bench for grid_lcd_writer
module tb_grid_lcd_writer;

  logic        clk;
  logic        reset;
  logic [15:0] grid;
  logic        busy;
  logic        frame_done;

  grid_lcd_writer_if lcd_bus ();

  grid_lcd_writer dut (
    .clk        (clk),
    .reset      (reset),
    .grid       (grid),
    .lcd        (lcd_bus),
    .busy       (busy),
    .frame_done (frame_done)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int fall_cyc = 0;
  logic prev_e = 1'b0;
  logic [8:0] cap_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // capture {rs,data} at each rising edge of e; remember last falling edge cycle
  always @(negedge clk) begin
    if (lcd_bus.lcd_e && !prev_e) cap_q.push_back({lcd_bus.lcd_rs, lcd_bus.lcd_data});
    if (!lcd_bus.lcd_e && prev_e) fall_cyc = cyc;
    prev_e = lcd_bus.lcd_e;
  end

  // expected {rs,data} for byte i of a frame drawing grid g
  function automatic logic [8:0] exp_byte(input logic [15:0] g, input int i);
    if (i == 0) return {1'b0, 8'h80};
    if (i == 9) return {1'b0, 8'hC0};
    if (i < 9)  return {1'b1, g[16 - i] ? 8'h2A : 8'h20};
    return {1'b1, g[17 - i] ? 8'h2A : 8'h20};
  endfunction

  task automatic wait_for(input int sel, input logic val, input int limit,
                          output int at, output bit ok);
    logic s;
    ok = 1'b0;
    at = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      case (sel)
        0:       s = busy;
        1:       s = frame_done;
        default: s = lcd_bus.lcd_e;
      endcase
      if (s === val) begin
        at = cyc;
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    int at;
    bit ok;
    logic [8:0] init_exp[4];
    init_exp = '{9'h038, 9'h00C, 9'h006, 9'h001};
    reset = 1'b0;
    grid  = 16'h0000;
    repeat (5) @(negedge clk);
    total++;
    if ({lcd_bus.lcd_e, lcd_bus.lcd_rs, lcd_bus.lcd_rw, busy, frame_done} !== 5'b0) begin
      bad++;
      $display("FAIL reset_ctrl got e/rs/rw/busy/fd=%b want=00000",
               {lcd_bus.lcd_e, lcd_bus.lcd_rs, lcd_bus.lcd_rw, busy, frame_done});
    end
    total++;
    if (lcd_bus.lcd_data !== 8'h00) begin
      bad++;
      $display("FAIL reset_data got=%h want=00", lcd_bus.lcd_data);
    end
    cap_q.delete();
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL init_busy got=%b want=1", busy);
    end
    wait_for(0, 1'b0, 100, at, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL init_end timeout got=busy_high want=busy_low");
    end
    total++;
    if (at - fall_cyc != 12) begin
      bad++;
      $display("FAIL clear_hold got=%0d want=12", at - fall_cyc);
    end
    total++;
    if (cap_q.size() != 4) begin
      bad++;
      $display("FAIL init_count got=%0d want=4", cap_q.size());
    end
    for (int i = 0; i < 4 && i < cap_q.size(); i++) begin
      total++;
      if (cap_q[i] !== init_exp[i]) begin
        bad++;
        $display("FAIL init_byte%0d got=%h want=%h", i, cap_q[i], init_exp[i]);
      end
    end
    cap_q.delete();
  endtask

  task automatic test_first_frame();
    int f, d;
    bit ok1, ok2;
    wait_for(0, 1'b1, 10, f, ok1);
    wait_for(1, 1'b1, 200, d, ok2);
    total++;
    if (!(ok1 && ok2) || (d - f != 126)) begin
      bad++;
      $display("FAIL frame0_len got=%0d want=126", d - f);
    end
    total++;
    if (cap_q.size() != 18) begin
      bad++;
      $display("FAIL frame0_count got=%0d want=18", cap_q.size());
    end
    for (int i = 0; i < 18 && i < cap_q.size(); i++) begin
      total++;
      if (cap_q[i] !== exp_byte(16'h0000, i)) begin
        bad++;
        $display("FAIL frame0_byte%0d got=%h want=%h", i, cap_q[i], exp_byte(16'h0000, i));
      end
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || frame_done !== 1'b0) begin
      bad++;
      $display("FAIL frame0_idle got busy/fd=%b%b want=00", busy, frame_done);
    end
  endtask

  task automatic test_grid_frame(input logic [15:0] g);
    int f, d;
    bit ok1, ok2;
    cap_q.delete();
    grid = g;
    wait_for(0, 1'b1, 10, f, ok1);
    wait_for(1, 1'b1, 200, d, ok2);
    total++;
    if (!(ok1 && ok2) || (d - f != 126)) begin
      bad++;
      $display("FAIL frame_%h_len got=%0d want=126", g, d - f);
    end
    total++;
    if (cap_q.size() != 18) begin
      bad++;
      $display("FAIL frame_%h_count got=%0d want=18", g, cap_q.size());
    end
    for (int i = 0; i < 18 && i < cap_q.size(); i++) begin
      total++;
      if (cap_q[i] !== exp_byte(g, i)) begin
        bad++;
        $display("FAIL frame_%h_byte%0d got=%h want=%h", g, i, cap_q[i], exp_byte(g, i));
      end
    end
  endtask

  task automatic test_change_mid_frame();
    int f, d1, d2;
    bit ok1, ok2, ok3;
    cap_q.delete();
    grid = 16'h0080;
    wait_for(0, 1'b1, 10, f, ok1);
    repeat (40) @(negedge clk);
    grid = 16'h8000;
    wait_for(1, 1'b1, 200, d1, ok2);
    total++;
    if (!(ok1 && ok2) || cap_q.size() != 18) begin
      bad++;
      $display("FAIL midchg_first got=%0d bytes want=18", cap_q.size());
    end
    for (int i = 0; i < 18 && i < cap_q.size(); i++) begin
      total++;
      if (cap_q[i] !== exp_byte(16'h0080, i)) begin
        bad++;
        $display("FAIL midchg_old_byte%0d got=%h want=%h", i, cap_q[i], exp_byte(16'h0080, i));
      end
    end
    cap_q.delete();
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL midchg_idle got=%b want=0", busy);
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL midchg_restart got=%b want=1", busy);
    end
    wait_for(1, 1'b1, 200, d2, ok3);
    total++;
    if (!ok3 || (d2 - d1 != 128)) begin
      bad++;
      $display("FAIL midchg_gap got=%0d want=128", d2 - d1);
    end
    for (int i = 0; i < 18 && i < cap_q.size(); i++) begin
      total++;
      if (cap_q[i] !== exp_byte(16'h8000, i)) begin
        bad++;
        $display("FAIL midchg_new_byte%0d got=%h want=%h", i, cap_q[i], exp_byte(16'h8000, i));
      end
    end
    cap_q.delete();
    repeat (200) @(negedge clk);
    total++;
    if (cap_q.size() != 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL stable_quiet got=%0d pulses busy=%b want=0 pulses busy=0", cap_q.size(), busy);
    end
  endtask

  task automatic test_reset_mid_frame();
    int at, f, d;
    bit ok1, ok2, ok3, ok4, ok5;
    logic [8:0] init_exp[4];
    init_exp = '{9'h038, 9'h00C, 9'h006, 9'h001};
    grid = 16'hFF00;
    wait_for(0, 1'b1, 10, at, ok1);
    repeat (20) @(negedge clk);
    wait_for(2, 1'b1, 20, at, ok2);
    total++;
    if (!(ok1 && ok2)) begin
      bad++;
      $display("FAIL rstmid_e timeout got=e_low want=e_high");
    end
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (lcd_bus.lcd_e !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_abort got e/busy=%b%b want=00", lcd_bus.lcd_e, busy);
    end
    @(negedge clk);
    cap_q.delete();
    reset = 1'b1;
    wait_for(0, 1'b0, 100, at, ok3);
    total++;
    if (!ok3 || cap_q.size() != 4) begin
      bad++;
      $display("FAIL rstmid_init_count got=%0d want=4", cap_q.size());
    end
    for (int i = 0; i < 4 && i < cap_q.size(); i++) begin
      total++;
      if (cap_q[i] !== init_exp[i]) begin
        bad++;
        $display("FAIL rstmid_init%0d got=%h want=%h", i, cap_q[i], init_exp[i]);
      end
    end
    cap_q.delete();
    wait_for(0, 1'b1, 10, f, ok4);
    wait_for(1, 1'b1, 200, d, ok5);
    total++;
    if (!(ok4 && ok5) || (d - f != 126) || cap_q.size() != 18) begin
      bad++;
      $display("FAIL rstmid_frame got len=%0d bytes=%0d want len=126 bytes=18", d - f, cap_q.size());
    end
    for (int i = 0; i < 18 && i < cap_q.size(); i++) begin
      total++;
      if (cap_q[i] !== exp_byte(16'hFF00, i)) begin
        bad++;
        $display("FAIL rstmid_byte%0d got=%h want=%h", i, cap_q[i], exp_byte(16'hFF00, i));
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    grid  = 16'h0000;
    test_reset();
    test_first_frame();
    test_grid_frame(16'h0080);
    test_grid_frame(16'h0180);
    test_change_mid_frame();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
